// File: rtl/serial_frame_scheduler_if.sv
// Bundle between the frame scheduler and its requesters / pad logic.
// The slave modport is the scheduler side; master is the requester/pad side.
interface serial_frame_scheduler_if #(
    parameter int NREQ = 4
);
    // Handshake: req[k] is a level that the requester holds until done[k] pulses
    // for one cycle (with rd_valid); req is sampled only in the count-39 cycle.
    logic              enable;
    logic [NREQ-1:0]   req;
    logic [NREQ*8-1:0] cmd;
    logic              dq_in;
    logic [5:0]        count40;
    logic [NREQ-1:0]   grant;
    logic              busy;
    logic              dq_out;
    logic [NREQ-1:0]   done;
    logic [7:0]        rd_data;
    logic              rd_valid;

    modport master (
        output enable, req, cmd, dq_in,
        input  count40, grant, busy, dq_out, done, rd_data, rd_valid
    );

    modport slave (
        input  enable, req, cmd, dq_in,
        output count40, grant, busy, dq_out, done, rd_data, rd_valid
    );
endinterface

// File: rtl/serial_frame_scheduler.sv
// 40-cycle frame timer with a round-robin / fixed-priority arbiter that
// serialises the owner's command byte and deserialises one read byte per frame.
module serial_frame_scheduler #(
    parameter int NREQ       = 4,
    parameter bit FIXED_PRIO = 1'b0
) (
    input logic                     clk,
    input logic                     rst,
    serial_frame_scheduler_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [5:0]      cnt_q;
    logic [5:0]      cnt_nxt;
    logic            last;
    logic [NREQ-1:0] grant_q;
    logic [PW-1:0]   ptr_q;
    logic [7:0]      cmd_q;
    logic            dq_q;
    logic [7:0]      shreg_q;
    logic [7:0]      rd_data_q;
    logic            rd_valid_q;
    logic [NREQ-1:0] done_q;

    logic [NREQ-1:0] win;
    logic [PW-1:0]   win_idx;
    logic            win_any;
    logic [7:0]      win_cmd;
    logic            dq_next;
    logic [5:0]      slot;
    logic [2:0]      bit_idx;
    logic            sample;

    assign last    = (cnt_q == 6'd39);
    assign cnt_nxt = last ? 6'd0 : cnt_q + 6'd1;

    // Search starts just after the last winner (round-robin) or at index 0 (fixed).
    always_comb begin
        int idx;
        win     = '0;
        win_idx = '0;
        win_any = 1'b0;
        win_cmd = '0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            if (FIXED_PRIO) idx = k;
            else            idx = (int'(ptr_q) + 1 + k) % NREQ;
            if (!win_any && bus.req[idx]) begin
                win_any      = 1'b1;
                win[idx]     = 1'b1;
                win_idx      = PW'(idx);
                win_cmd      = bus.cmd[8*idx +: 8];
            end
        end
    end

    // Write slot i covers counts 2+2i and 3+2i; bit 7-i is ~slot[3:1].
    always_comb begin
        slot    = cnt_nxt - 6'd2;
        bit_idx = ~slot[3:1];
        dq_next = 1'b0;
        if (grant_q != '0 && cnt_nxt >= 6'd2 && cnt_nxt <= 6'd17)
            dq_next = cmd_q[bit_idx];
    end

    assign sample = (cnt_q >= 6'd21) && (cnt_q <= 6'd35) && cnt_q[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            grant_q    <= '0;
            ptr_q      <= PW'(NREQ - 1);
            cmd_q      <= '0;
            dq_q       <= 1'b0;
            shreg_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= '0;
        end else begin
            cnt_q      <= cnt_nxt;
            dq_q       <= dq_next;
            done_q     <= '0;
            rd_valid_q <= 1'b0;
            if (last) begin
                if (bus.enable && win_any) begin
                    grant_q <= win;
                    cmd_q   <= win_cmd;
                    ptr_q   <= win_idx;
                end else begin
                    grant_q <= '0;
                end
            end
            if (sample) shreg_q <= {shreg_q[6:0], bus.dq_in};
            // The last read bit arrives on this same edge, so fold it in directly.
            if (cnt_q == 6'd35 && grant_q != '0) begin
                done_q     <= grant_q;
                rd_valid_q <= 1'b1;
                rd_data_q  <= {shreg_q[6:0], bus.dq_in};
            end
        end
    end

    assign bus.count40  = cnt_q;
    assign bus.grant    = grant_q;
    assign bus.busy     = |grant_q;
    assign bus.dq_out   = dq_q;
    assign bus.done     = done_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
endmodule

// File: tb/tb_serial_frame_scheduler.sv
// Frame-by-frame directed bench for serial_frame_scheduler: a round-robin and a
// fixed-priority instance run in lockstep and are checked every cycle.
module tb_serial_frame_scheduler;
    localparam logic [31:0] CMD_ALL = {8'h81, 8'hC3, 8'hA5, 8'h5A};

    typedef struct packed {
        logic [3:0] req;
        logic [3:0] fp_req;
        logic       en;
        logic [3:0] late_req;
        logic       en_off;
        logic       rst20;
        logic [3:0] g;
        logic [3:0] fg;
        logic [7:0] rbyte;
    } frame_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_frame_scheduler_if #(.NREQ(4)) rr_if ();
    serial_frame_scheduler_if #(.NREQ(4)) fp_if ();

    serial_frame_scheduler #(.NREQ(4), .FIXED_PRIO(1'b0)) dut_rr (
        .clk(clk), .rst(rst), .bus(rr_if.slave)
    );
    serial_frame_scheduler #(.NREQ(4), .FIXED_PRIO(1'b1)) dut_fp (
        .clk(clk), .rst(rst), .bus(fp_if.slave)
    );

    always_comb begin
        fp_if.enable = rr_if.enable;
        fp_if.cmd    = rr_if.cmd;
        fp_if.dq_in  = rr_if.dq_in;
    end

    int n_cmp = 0;
    int n_bad = 0;
    logic [23:0] exp_q[$];

    // Reference frame position, restarted by every sampled reset.
    int m_cnt = 0;
    bit m_valid = 1'b0;
    bit m_in_reset = 1'b0;
    always @(posedge clk) begin
        m_in_reset <= rst;
        if (rst) begin
            m_cnt   <= 0;
            m_valid <= 1'b1;
        end else if (m_valid) begin
            m_cnt <= (m_cnt == 39) ? 0 : m_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t cnt=%0d: got %0h expected %0h", name, $time, m_cnt, act, exp);
        end
    endtask

    function automatic logic [7:0] cmd_of(input logic [3:0] g);
        logic [31:0] c;
        logic [7:0] r;
        c = CMD_ALL;
        r = '0;
        for (int k = 0; k < 4; k++)
            if (g[k]) r = c[8*k +: 8];
        return r;
    endfunction

    // Scoreboard monitor: pops one frame record at each count 0.
    logic [3:0] cur_g = '0, cur_fg = '0;
    logic [7:0] cur_w = '0, cur_r = '0, held_rd = '0;
    always @(negedge clk) begin
        logic exp_dq;
        logic [3:0] exp_done;
        if (m_valid) begin
            if (m_in_reset) begin
                check("reset_outs", 32'({rr_if.count40, rr_if.grant, rr_if.busy, rr_if.dq_out,
                      rr_if.done, rr_if.rd_valid, rr_if.rd_data}), 32'd0);
                check("reset_fp", 32'({fp_if.grant, fp_if.done, fp_if.rd_valid}), 32'd0);
                cur_g = '0; cur_fg = '0; cur_w = '0; cur_r = '0; held_rd = '0;
            end else begin
                if (m_cnt == 0) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL exp_q_empty t=%0t: got size 0 expected a frame record", $time);
                        cur_g = '0; cur_fg = '0;
                    end else begin
                        {cur_g, cur_fg, cur_w, cur_r} = exp_q.pop_front();
                    end
                end
                check("count40", 32'(rr_if.count40), 32'(m_cnt));
                check("count40_fp", 32'(fp_if.count40), 32'(m_cnt));
                check("grant_rr", 32'(rr_if.grant), 32'(cur_g));
                check("busy_rr", 32'(rr_if.busy), 32'(cur_g != 4'd0));
                check("grant_fp", 32'(fp_if.grant), 32'(cur_fg));
                exp_dq = 1'b0;
                if (cur_g != 4'd0 && m_cnt >= 2 && m_cnt <= 17)
                    exp_dq = cur_w[7 - ((m_cnt - 2) / 2)];
                check("dq_out", 32'(rr_if.dq_out), 32'(exp_dq));
                exp_done = (m_cnt == 36) ? cur_g : 4'd0;
                check("done", 32'(rr_if.done), 32'(exp_done));
                check("rd_valid", 32'(rr_if.rd_valid), 32'(exp_done != 4'd0));
                if (exp_done != 4'd0) held_rd = cur_r;
                check("rd_data", 32'(rr_if.rd_data), 32'(held_rd));
            end
        end
    end

    task automatic wait_cnt(input int c);
        int budget;
        budget = 0;
        do begin
            @(negedge clk);
            budget++;
            if (budget > 100) begin
                $display("FAIL wait_cnt: got no count %0d within 100 cycles, expected it within 40", c);
                $fatal(1, "frame timing lost");
            end
        end while (m_cnt != c);
    endtask

    task automatic run_frame(input frame_t f);
        wait_cnt(39);
        rr_if.req    = f.req;
        fp_if.req    = f.fp_req;
        rr_if.enable = f.en;
        rr_if.cmd    = CMD_ALL;
        exp_q.push_back({f.g, f.fg, cmd_of(f.g), f.rbyte});
        for (int c = 0; c < 39; c++) begin
            @(negedge clk);
            if (m_cnt == 4) rr_if.cmd = ~CMD_ALL;
            if (m_cnt == 5 && f.late_req != 4'd0) rr_if.req = f.late_req;
            if (m_cnt == 10 && f.en_off) rr_if.enable = 1'b0;
            if (m_cnt >= 21 && m_cnt <= 35 && (m_cnt % 2) == 1)
                rr_if.dq_in = f.rbyte[7 - ((m_cnt - 21) / 2)];
            else
                rr_if.dq_in = 1'($urandom_range(0, 1));
            if (m_cnt == 20 && f.rst20) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                return;
            end
        end
    endtask

    function automatic frame_t fr(input logic [3:0] req, input logic [3:0] fp_req, input logic en,
                                  input logic [3:0] late, input logic en_off, input logic rst20,
                                  input logic [3:0] g, input logic [3:0] fg, input logic [7:0] rbyte);
        frame_t f;
        f = '{req, fp_req, en, late, en_off, rst20, g, fg, rbyte};
        return f;
    endfunction

    frame_t plan[12];

    initial begin
        // Hand-computed grants; round-robin pointer starts at 3 after reset.
        plan[0]  = fr(4'b0010, 4'b1100, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0010, 4'b0100, 8'h3C);
        plan[1]  = fr(4'b1011, 4'b1100, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b1000, 4'b0100, 8'hA1);
        plan[2]  = fr(4'b1011, 4'b1100, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0001, 4'b0100, 8'h0F);
        plan[3]  = fr(4'b1011, 4'b1000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0010, 4'b1000, 8'hF0);
        plan[4]  = fr(4'b1011, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b1000, 4'b0000, 8'h96);
        plan[5]  = fr(4'b0000, 4'b0110, 1'b1, 4'b0100, 1'b0, 1'b0, 4'b0000, 4'b0010, 8'h00);
        plan[6]  = fr(4'b0100, 4'b0011, 1'b1, 4'b0000, 1'b1, 1'b0, 4'b0100, 4'b0001, 8'h5C);
        plan[7]  = fr(4'b0100, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 8'h00);
        plan[8]  = fr(4'b0001, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, 4'b0001, 4'b0000, 8'hFF);
        plan[9]  = fr(4'b1001, 4'b1001, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0001, 4'b0001, 8'hE7);
        plan[10] = fr(4'b1001, 4'b1100, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b1000, 4'b0100, 8'h18);
        plan[11] = fr(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 8'h00);

        rr_if.enable = 1'b0;
        rr_if.req    = '0;
        rr_if.cmd    = CMD_ALL;
        rr_if.dq_in  = 1'b0;
        fp_if.req    = '0;
        rst          = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) run_frame(plan[i]);
        @(negedge clk);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end by t=%0t, expected end well before", $time);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/serial_frame_scheduler.md
Name: serial_frame_scheduler

Overview:
- Frame timer and requester arbiter for the serial interface controller.
- Generates the 0..39 `count40` cycle counter that paces the interface FSM.
- Shares each 40-cycle frame among NREQ command sources using round-robin or fixed priority.
- Serialises the granted 8-bit command onto the write slots, deserialises 8 read bits from the read slots, and returns them with a done pulse.

Parameters:
- NREQ, 4, number of requesters (2..8).
- FIXED_PRIO, 0, 0 = round-robin; 1 = fixed priority, lowest index wins.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  allows new grants; an in-flight frame always completes.
- req  in  NREQ  per-requester frame request, level.
- cmd  in  NREQ*8  command bytes; requester k uses bits [8k+7:8k].
- dq_in  in  1  serial read data from the pad.
- count40  out  6  frame cycle counter for the interface FSM.
- grant  out  NREQ  one-hot owner of the current frame; 0 = empty frame.
- busy  out  1  equals |grant.
- dq_out  out  1  serial write data to the pad.
- done  out  NREQ  one-cycle completion pulse to the owner.
- rd_data  out  8  captured read byte.
- rd_valid  out  1  one-cycle strobe, coincident with done.

Behaviour:
- Reset: clk and rst are one clock, and rst is synchronous and active-high, as already decided.
- Reset values: count40=0, grant=0, dq_out=0, done=0, rd_valid=0, rd_data=0. Round-robin pointer = NREQ-1, so req[0] has first priority.
- Reset mid-frame aborts the frame: no done, no rd_valid.
- Counter: after reset it increments by 1 every cycle 0..39, wraps 39→0, never stops, and is independent of enable and req.
- Arbitration happens only on the edge leaving count 39, and only if enable=1 and req≠0:
  - Round-robin: grant goes to the first set req strictly after the last granted index, cyclically, and the pointer updates to the winner.
  - Fixed priority: grant goes to the lowest set index.
  - The winner's cmd byte is latched in the same edge; later cmd changes are ignored.
- grant is registered and holds through counts 0..39 of the frame. If nothing is granted, grant=0 for the whole frame and dq_out stays 0.
- Write slots (i=0..7, MSB first): dq_out = latched cmd[7-i] during counts 2+2i and 3+2i; dq_out=0 at every other count. dq_out is registered, updated on the edge leaving count 1+2i.
- Read slots:
  - The count-18/19 slot is turnaround; dq_in is ignored there.
  - For j=0..7, dq_in is sampled on the edge leaving count 21+2j into rd_data bit 7-j (MSB first), via a shift register.
  - rd_data updates only with rd_valid.
- Completion: at count 36 of a granted frame, done[owner]=1 and rd_valid=1 for exactly one cycle. rd_data is valid in that cycle and held until the next rd_valid.
- grant clears on the edge leaving 39 unless re-granted.
- Requester protocol: hold req until done. Drop req by count 38 to avoid a repeat grant, since req is sampled only at count 39. Requests arriving at any other count wait for the next count 39.
- Simultaneous events:
  - Several reqs at count 39 → one grant per frame.
  - enable falling mid-frame → the current frame still finishes with done; no new grant.
  - A req of the current owner at count 39 competes normally: round-robin serves others first if they request; fixed priority may re-grant it.
- Back-to-back frames: done at count 36, new grant at count 0 of the following frame; no idle frame is inserted.

Test Plan:
- Reset then idle: rst=1 for 3 cycles → all outputs 0. After release, count40 reads 0,1,…,39,0; grant stays 0 and dq_out stays 0 throughout.
- Single write/read: req[1]=1, cmd[15:8]=8'hA5, dq_in driven 8'h3C MSB first at counts 21,23,…,35 → grant=4'b0010 at counts 0..39. dq_out = 1,0,1,0,0,1,0,1 over slots 2..17. At count 36, done[1]=1, rd_valid=1, rd_data=8'h3C.
- Round-robin fairness: req=4'b1011 held for 4 frames → grants 0001, 0010, 1000, 0001.
- Fixed priority (FIXED_PRIO=1): req=4'b1100 for 3 frames → grant 0100 each frame; req[3] is never served.
- Late request and enable: req[2] rising at count 5 → no grant until the next frame. enable=0 at count 10 of a granted frame → done still fires at 36, and the next frame has grant=0.
- Reset mid-frame: rst pulsed at count 20 of a granted frame → no done or rd_valid. count40 restarts at 0, and the next grant goes to req[0] if it is requesting.
